// File: rtl/demux16bit122_stream.sv
// demux16bit122_stream: 1-to-2 streaming demultiplexer with a one-entry
// registered buffer per output port and per-port accepted-word counters.
// The input is steered by sel; each port keeps full throughput because a
// buffered word may leave and be replaced in the same cycle.
module demux16bit122_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic [WIDTH-1:0] a_data_r;
  logic             a_valid_r;
  logic [WIDTH-1:0] b_data_r;
  logic             b_valid_r;
  logic [CNT_W-1:0] cnt_a_r;
  logic [CNT_W-1:0] cnt_b_r;

  logic             in_ready_s;
  logic             load_a_s;
  logic             load_b_s;

  // Ready looks only at the selected port: its buffer is empty or draining now.
  always_comb begin
    in_ready_s = 1'b0;
    if (sel == 1'b0) begin
      in_ready_s = (!a_valid_r) || a_ready;
    end else begin
      in_ready_s = (!b_valid_r) || b_ready;
    end
  end

  // Decode an accepted input word into a load of exactly one port buffer.
  always_comb begin
    load_a_s = 1'b0;
    load_b_s = 1'b0;
    if (in_valid && in_ready_s) begin
      load_a_s = (sel == 1'b0);
      load_b_s = (sel == 1'b1);
    end else begin
      load_a_s = 1'b0;
      load_b_s = 1'b0;
    end
  end

  // Port A buffer: load wins over drain so a simultaneous pop+push keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_data_r  <= {WIDTH{1'b0}};
      a_valid_r <= 1'b0;
    end else if (load_a_s) begin
      a_data_r  <= in_data;
      a_valid_r <= 1'b1;
    end else if (a_valid_r && a_ready) begin
      a_valid_r <= 1'b0;
    end
  end

  // Port B buffer: same policy as port A, fully independent of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_data_r  <= {WIDTH{1'b0}};
      b_valid_r <= 1'b0;
    end else if (load_b_s) begin
      b_data_r  <= in_data;
      b_valid_r <= 1'b1;
    end else if (b_valid_r && b_ready) begin
      b_valid_r <= 1'b0;
    end
  end

  // Accepted-word counters, wrapping naturally modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_r <= {CNT_W{1'b0}};
      cnt_b_r <= {CNT_W{1'b0}};
    end else begin
      if (load_a_s) begin
        cnt_a_r <= cnt_a_r + CNT_W'(1);
      end
      if (load_b_s) begin
        cnt_b_r <= cnt_b_r + CNT_W'(1);
      end
    end
  end

  assign in_ready = in_ready_s;
  assign a_data   = a_data_r;
  assign a_valid  = a_valid_r;
  assign b_data   = b_data_r;
  assign b_valid  = b_valid_r;
  assign cnt_a    = cnt_a_r;
  assign cnt_b    = cnt_b_r;

endmodule
